// File: rtl/feature_pkg.sv
// Shared types and helpers for the shape-feature extractor.
package feature_pkg;

   typedef enum logic [2:0] {StIdle, StLoad, StDiv, StStore, StDone} state_e;

   function automatic int unsigned div_width(input int unsigned cw, input int unsigned frac_bits);
      return 2 * cw + frac_bits;
   endfunction

   function automatic logic [63:0] sat_quot(input logic [63:0] q, input int unsigned q_w);
      logic [63:0] max_q;
      max_q = (64'd1 << q_w) - 64'd1;
      return (q > max_q) ? max_q : q;
   endfunction

endpackage

// File: rtl/feature_div.sv
// Restoring unsigned divider, one quotient bit per cycle; done flags the final step.
module feature_div #(
   parameter int unsigned DIV_W = 28
) (
   input  logic             pixelclk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic             done
);
   localparam int unsigned CNT_W = $clog2(DIV_W);

   logic [DIV_W-1:0] rem_q, quo_q, dvs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;
   logic [DIV_W:0]   shifted, diff;

   always_comb begin
      shifted = {rem_q, quo_q[DIV_W-1]};
      diff    = shifted - {1'b0, dvs_q};
   end

   assign done     = run_q && (cnt_q == CNT_W'(DIV_W - 1));
   assign quotient = quo_q;

   always_ff @(posedge pixelclk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         if (!diff[DIV_W]) begin
            rem_q <= diff[DIV_W-1:0];
            quo_q <= {quo_q[DIV_W-2:0], 1'b1};
         end else begin
            rem_q <= shifted[DIV_W-1:0];
            quo_q <= {quo_q[DIV_W-2:0], 1'b0};
         end
         cnt_q <= cnt_q + CNT_W'(1);
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/shape_feature_calc.sv
// Per-frame pixel count, box sides and aspect/fill ratios for NCH mask channels,
// all ratio jobs sharing one sequential divider.
module shape_feature_calc
   import feature_pkg::*;
#(
   parameter int unsigned NCH       = 2,
   parameter int unsigned CW        = 12,
   parameter int unsigned AREA_W    = 24,
   parameter int unsigned FRAC_BITS = 4,
   parameter int unsigned Q_W       = 8
) (
   input  logic                  pixelclk,
   input  logic                  rst,
   input  logic [NCH-1:0]        i_bit,
   input  logic                  i_hs,
   input  logic                  i_vs,
   input  logic                  i_de,
   input  logic [NCH*CW-1:0]     hcount_l,
   input  logic [NCH*CW-1:0]     hcount_r,
   input  logic [NCH*CW-1:0]     vcount_l,
   input  logic [NCH*CW-1:0]     vcount_r,
   output logic [NCH*AREA_W-1:0] o_area,
   output logic [NCH*CW-1:0]     o_len,
   output logic [NCH*CW-1:0]     o_wid,
   output logic [NCH*Q_W-1:0]    o_aspect,
   output logic [NCH*Q_W-1:0]    o_fill,
   output logic                  o_valid,
   output logic                  o_busy,
   output logic                  o_drop
);
   localparam int unsigned DIV_W = div_width(CW, FRAC_BITS);
   localparam int unsigned JOB_W = $clog2(2 * NCH);

   state_e           state_q;
   logic [JOB_W-1:0] job_q;
   logic             vs_r, vs_fall;
   logic             unused_hs;

   logic [AREA_W-1:0] cnt_q [NCH];
   logic [AREA_W-1:0] area_sh [NCH];
   logic [CW-1:0]     len_sh [NCH], wid_sh [NCH];
   logic [CW-1:0]     h_side [NCH], v_side [NCH], cur_len [NCH], cur_wid [NCH];
   logic [Q_W-1:0]    aspect_res [NCH], fill_res [NCH];

   logic [AREA_W-1:0] sel_area;
   logic [CW-1:0]     sel_len, sel_wid;
   logic              is_fill, div_start, div_done, div_zero;
   logic [DIV_W-1:0]  div_dividend, div_divisor, div_quot, q_full;
   logic [Q_W-1:0]    q_sat;

   assign unused_hs = i_hs;
   assign vs_fall   = !i_vs && vs_r;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         h_side[c]  = (hcount_r[c*CW +: CW] >= hcount_l[c*CW +: CW]) ?
                      hcount_r[c*CW +: CW] - hcount_l[c*CW +: CW] : '0;
         v_side[c]  = (vcount_r[c*CW +: CW] >= vcount_l[c*CW +: CW]) ?
                      vcount_r[c*CW +: CW] - vcount_l[c*CW +: CW] : '0;
         cur_len[c] = (h_side[c] >= v_side[c]) ? h_side[c] : v_side[c];
         cur_wid[c] = (h_side[c] >= v_side[c]) ? v_side[c] : h_side[c];
      end
   end

   // Even jobs compute aspect, odd jobs compute fill, for channel job_q/2.
   always_comb begin
      sel_area = '0;
      sel_len  = '0;
      sel_wid  = '0;
      for (int c = 0; c < NCH; c++) begin
         if ((job_q >> 1) == JOB_W'(c)) begin
            sel_area = area_sh[c];
            sel_len  = len_sh[c];
            sel_wid  = wid_sh[c];
         end
      end
      is_fill      = job_q[0];
      div_dividend = is_fill ? ((DIV_W'(sel_len) * DIV_W'(sel_wid)) << FRAC_BITS)
                             : (DIV_W'(sel_len) << FRAC_BITS);
      div_divisor  = is_fill ? DIV_W'(sel_area) : DIV_W'(sel_wid);
      div_zero     = (div_divisor == '0);
      q_full       = div_zero ? '1 : div_quot;
      q_sat        = Q_W'(sat_quot(64'(q_full), Q_W));
      div_start    = (state_q == StLoad);
   end

   feature_div #(
      .DIV_W(DIV_W)
   ) u_div (
      .pixelclk(pixelclk),
      .rst     (rst),
      .start   (div_start),
      .dividend(div_dividend),
      .divisor (div_divisor),
      .quotient(div_quot),
      .done    (div_done)
   );

   // A frame end always clears the counters, even when its snapshot is dropped.
   always_ff @(posedge pixelclk or posedge rst) begin
      if (rst) begin
         vs_r <= 1'b0;
         for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
      end else begin
         vs_r <= i_vs;
         for (int c = 0; c < NCH; c++) begin
            if (vs_fall) cnt_q[c] <= '0;
            else if (i_de && i_bit[c] && (cnt_q[c] != '1)) cnt_q[c] <= cnt_q[c] + AREA_W'(1);
         end
      end
   end

   always_ff @(posedge pixelclk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         job_q    <= '0;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_drop   <= 1'b0;
         o_area   <= '0;
         o_len    <= '0;
         o_wid    <= '0;
         o_aspect <= '0;
         o_fill   <= '0;
         for (int c = 0; c < NCH; c++) begin
            area_sh[c]    <= '0;
            len_sh[c]     <= '0;
            wid_sh[c]     <= '0;
            aspect_res[c] <= '0;
            fill_res[c]   <= '0;
         end
      end else begin
         o_valid <= 1'b0;
         o_busy  <= (state_q != StIdle);
         o_drop  <= vs_fall && (state_q != StIdle);
         unique case (state_q)
            StIdle: begin
               if (vs_fall) begin
                  for (int c = 0; c < NCH; c++) begin
                     area_sh[c] <= cnt_q[c];
                     len_sh[c]  <= cur_len[c];
                     wid_sh[c]  <= cur_wid[c];
                  end
                  job_q   <= '0;
                  state_q <= StLoad;
               end
            end
            StLoad: state_q <= StDiv;
            StDiv: if (div_done) state_q <= StStore;
            StStore: begin
               for (int c = 0; c < NCH; c++) begin
                  if ((job_q >> 1) == JOB_W'(c)) begin
                     if (is_fill) fill_res[c] <= q_sat;
                     else aspect_res[c] <= q_sat;
                  end
               end
               if (job_q == JOB_W'(2 * NCH - 1)) begin
                  state_q <= StDone;
               end else begin
                  job_q   <= job_q + JOB_W'(1);
                  state_q <= StLoad;
               end
            end
            StDone: begin
               for (int c = 0; c < NCH; c++) begin
                  o_area[c*AREA_W +: AREA_W] <= area_sh[c];
                  o_len[c*CW +: CW]          <= len_sh[c];
                  o_wid[c*CW +: CW]          <= wid_sh[c];
                  o_aspect[c*Q_W +: Q_W]     <= aspect_res[c];
                  o_fill[c*Q_W +: Q_W]       <= fill_res[c];
               end
               o_valid <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
